// File: rtl/des_keysched_fp_unit.sv
// DES helper: PC1-domain key-schedule register with PC2 round-key output,
// plus a registered final permutation (IP^-1) on the merged R16||L16 block.
module des_keysched_fp_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ks_load,
  input  logic [55:0] ks_key,
  input  logic        ks_adv,
  output logic [55:0] cd_out,
  output logic [47:0] rk,
  output logic [3:0]  rk_round,
  output logic        rk_valid,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic        fp_en,
  output logic [63:0] c,
  output logic        c_valid
);

  // Tables hold 1-based DES bit numbers, bit 1 being the vector MSB.
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] k);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = k[6'(56 - PC2_T[i])];
    return o;
  endfunction

  function automatic logic [63:0] fperm(input logic [63:0] b);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = b[6'(64 - FP_T[i])];
    return o;
  endfunction

  logic [55:0] cd_p1;
  logic [47:0] rk_p1;
  logic [3:0]  rnd_p0;
  logic [3:0]  rnd_p1;
  logic        vld_p1;
  logic [63:0] c_p1;
  logic        c_vld_p1;
  logic        two_p0;
  logic [55:0] rot_p0;

  // Stage 0: rotate C and D by the schedule amount for the current round
  always_comb begin
    two_p0 = !((rnd_p0 == 4'd0) || (rnd_p0 == 4'd1) || (rnd_p0 == 4'd8) || (rnd_p0 == 4'd15));
    rot_p0 = {rotl28(cd_p1[55:28], two_p0), rotl28(cd_p1[27:0], two_p0)};
  end

  // Stage 1: key-state / round-key registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_p1  <= '0;
      rk_p1  <= '0;
      rnd_p0 <= '0;
      rnd_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (ks_load) begin
      cd_p1  <= ks_key;
      rnd_p0 <= '0;
      vld_p1 <= 1'b0;
    end else if (ks_adv) begin
      cd_p1  <= rot_p0;
      rk_p1  <= pc2(rot_p0);
      rnd_p1 <= rnd_p0;
      rnd_p0 <= rnd_p0 + 4'd1;
      vld_p1 <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 1: final-permutation output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_p1     <= '0;
      c_vld_p1 <= 1'b0;
    end else begin
      c_vld_p1 <= fp_en;
      if (fp_en) c_p1 <= fperm({x0, x1});
    end
  end

  assign cd_out   = cd_p1;
  assign rk       = rk_p1;
  assign rk_round = rnd_p1;
  assign rk_valid = vld_p1;
  assign c        = c_p1;
  assign c_valid  = c_vld_p1;

endmodule

// File: tb/tb_des_keysched_fp_unit.sv
// Directed bench for des_keysched_fp_unit with a queue-based scoreboard.
module tb_des_keysched_fp_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ks_load = 1'b0;
  logic [55:0] ks_key = '0;
  logic        ks_adv = 1'b0;
  logic [55:0] cd_out;
  logic [47:0] rk;
  logic [3:0]  rk_round;
  logic        rk_valid;
  logic [31:0] x0 = '0;
  logic [31:0] x1 = '0;
  logic        fp_en = 1'b0;
  logic [63:0] c;
  logic        c_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [55:0] cd;
    logic [3:0]  rnd;
    logic [47:0] rk;
    bit          rk_known;
  } ks_exp_t;

  typedef struct {
    string       tag;
    logic [63:0] c;
  } fp_exp_t;

  ks_exp_t ks_q[$];
  fp_exp_t fp_q[$];

  localparam logic [55:0] KEY = 56'hF0CCAAF556678F;

  des_keysched_fp_unit dut (
    .clk(clk), .rst(rst), .ks_load(ks_load), .ks_key(ks_key), .ks_adv(ks_adv),
    .cd_out(cd_out), .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid),
    .x0(x0), .x1(x1), .fp_en(fp_en), .c(c), .c_valid(c_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] mrot(input logic [27:0] v, input int n);
    logic [27:0] t;
    t = v;
    for (int k = 0; k < n; k++) t = {t[26:0], t[27]};
    return t;
  endfunction

  function automatic int sched(input int r);
    return (r == 0 || r == 1 || r == 8 || r == 15) ? 1 : 2;
  endfunction

  task automatic pop_ks;
    ks_exp_t e;
    if (ks_q.size() == 0) begin
      check("ks_queue_empty", 64'd0, 64'd1);
      return;
    end
    e = ks_q.pop_front();
    check({e.tag, "_valid"}, 64'(rk_valid), 64'd1);
    check({e.tag, "_round"}, 64'(rk_round), 64'(e.rnd));
    check({e.tag, "_cd"}, 64'(cd_out), 64'(e.cd));
    if (e.rk_known) check({e.tag, "_rk"}, 64'(rk), 64'(e.rk));
  endtask

  task automatic pop_fp;
    fp_exp_t e;
    if (fp_q.size() == 0) begin
      check("fp_queue_empty", 64'd0, 64'd1);
      return;
    end
    e = fp_q.pop_front();
    check({e.tag, "_valid"}, 64'(c_valid), 64'd1);
    check(e.tag, c, e.c);
  endtask

  initial begin
    logic [55:0] mcd;
    ks_exp_t     ke;
    fp_exp_t     fe;

    // asynchronous reset from power-up, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    check("rst0_cd", 64'(cd_out), 64'd0);
    check("rst0_rk", 64'(rk), 64'd0);
    check("rst0_c", c, 64'd0);
    check("rst0_rkv", 64'(rk_valid), 64'd0);
    check("rst0_cv", 64'(c_valid), 64'd0);
    #10 rst = 1'b1;
    tick;

    // advance from the reset state yields a zero round key
    ks_adv = 1'b1;
    ke = '{tag: "adv_noload", cd: 56'd0, rnd: 4'd0, rk: 48'd0, rk_known: 1'b1};
    ks_q.push_back(ke);
    tick;
    ks_adv = 1'b0;
    pop_ks;
    tick;
    check("adv_noload_pulse_end", 64'(rk_valid), 64'd0);

    // load wins over a simultaneous advance
    ks_load = 1'b1;
    ks_adv  = 1'b1;
    ks_key  = KEY;
    tick;
    ks_load = 1'b0;
    ks_adv  = 1'b0;
    check("load_adv_rkv", 64'(rk_valid), 64'd0);
    check("load_adv_cd", 64'(cd_out), 64'(KEY));
    check("load_adv_rk_hold", 64'(rk), 64'd0);

    // 16 back-to-back advances through the whole shift schedule
    mcd = KEY;
    ks_adv = 1'b1;
    for (int r = 0; r < 16; r++) begin
      mcd = {mrot(mcd[55:28], sched(r)), mrot(mcd[27:0], sched(r))};
      ke.tag = $sformatf("round%0d", r);
      ke.cd = mcd;
      ke.rnd = 4'(r);
      ke.rk_known = 1'b1;
      case (r)
        0:  ke.rk = 48'h1B02EFFC7072;
        1:  ke.rk = 48'h79AED9DBC9E5;
        15: ke.rk = 48'hCB3D8B0E17F5;
        default: ke.rk_known = 1'b0;
      endcase
      ks_q.push_back(ke);
      tick;
      pop_ks;
      if (r == 0) check("round0_cd_const", 64'(cd_out), 64'h00E19955FAACCF1E);
    end
    check("sched_wrap_cd", 64'(cd_out), 64'(KEY));

    // counter wrapped: the next round repeats round 0
    ke = '{tag: "round_wrap", cd: 56'hE19955FAACCF1E, rnd: 4'd0, rk: 48'h1B02EFFC7072, rk_known: 1'b1};
    ks_q.push_back(ke);
    tick;
    ks_adv = 1'b0;
    pop_ks;
    tick;
    check("hold_rkv", 64'(rk_valid), 64'd0);
    check("hold_round", 64'(rk_round), 64'd0);
    check("hold_rk", 64'(rk), 64'h1B02EFFC7072);

    // final permutation, one vector per cycle, with a concurrent advance
    ks_adv = 1'b1;
    fp_en  = 1'b1;
    x0 = 32'h0A4CD995; x1 = 32'h43423234;
    fe = '{tag: "fp_vec", c: 64'h85E813540F0AB405};
    fp_q.push_back(fe);
    ke = '{tag: "adv_with_fp", cd: {mrot(56'hE19955FAACCF1E >> 28, 1), mrot(28'hACCF1E, 1)},
           rnd: 4'd1, rk: 48'h79AED9DBC9E5, rk_known: 1'b1};
    ke.cd = {mrot(28'hE19955F, 1), mrot(28'hAACCF1E, 1)};
    ks_q.push_back(ke);
    tick;
    ks_adv = 1'b0;
    pop_ks;
    pop_fp;
    x0 = 32'h0; x1 = 32'h0;
    fe = '{tag: "fp_zero", c: 64'h0};
    fp_q.push_back(fe);
    tick;
    pop_fp;
    x0 = 32'hFFFFFFFF; x1 = 32'hFFFFFFFF;
    fe = '{tag: "fp_ones", c: 64'hFFFFFFFFFFFFFFFF};
    fp_q.push_back(fe);
    tick;
    pop_fp;
    x0 = 32'h80000000; x1 = 32'h0;
    fe = '{tag: "fp_msb", c: 64'h0000000000000040};
    fp_q.push_back(fe);
    tick;
    pop_fp;
    fp_en = 1'b0;
    x0 = 32'h12345678; x1 = 32'h9ABCDEF0;
    tick;
    check("fp_idle_cv", 64'(c_valid), 64'd0);
    check("fp_idle_hold", c, 64'h0000000000000040);

    // mid-stream reset discards in-flight work without waiting for an edge
    fp_en  = 1'b1;
    ks_adv = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst1_cd", 64'(cd_out), 64'd0);
    check("rst1_rk", 64'(rk), 64'd0);
    check("rst1_round", 64'(rk_round), 64'd0);
    check("rst1_c", c, 64'd0);
    check("rst1_rkv", 64'(rk_valid), 64'd0);
    check("rst1_cv", 64'(c_valid), 64'd0);
    tick;
    check("rst1_held_c", c, 64'd0);
    check("rst1_held_cv", 64'(c_valid), 64'd0);
    fp_en  = 1'b0;
    ks_adv = 1'b0;
    rst    = 1'b1;
    tick;

    check("queues_drained", 64'(ks_q.size() + fp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_keysched_fp_unit.md
Name: des_keysched_fp_unit

Overview:
- Clocked helper block for the DES datapath with two independent registered sub-paths.
- Key path: holds the 56-bit PC1-permuted key state (C||D) and, on each advance, rotates it per the DES shift schedule and emits the 48-bit PC2 round key.
- Output path: merges two 32-bit halves into a 64-bit word and applies the DES final permutation (IP^-1).
- Sits between the round datapath and the ciphertext output.

Parameters:
none (widths fixed by DES: key state 56, round key 48, block 64, half 32, 16 rounds)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  asynchronous active-low reset
ks_load  in  1  capture ks_key into the key state; round counter cleared to 0
ks_key  in  56  PC1-permuted key, C = [55:28], D = [27:0]
ks_adv  in  1  perform one key-schedule round
cd_out  out  56  current key state register
rk  out  48  registered round key
rk_round  out  4  round index (0..15) that produced rk
rk_valid  out  1  1-cycle pulse, rk updated this cycle
x0  in  32  upper half for merge (caller supplies R16)
x1  in  32  lower half for merge (caller supplies L16)
fp_en  in  1  compute output this cycle
c  out  64  registered FP({x0,x1})
c_valid  out  1  1-cycle pulse, c updated

Behaviour:
- Bit convention: DES bit 1 = MSB of each vector; tables are the standard FIPS 46-3 PC2 and IP^-1 tables.
- Reset (rst=0, async): cd_out, rk, rk_round, round counter, c = 0; rk_valid = c_valid = 0. Takes effect immediately; any in-flight operation is discarded.
- Shift schedule: internal round counter r (4 bits). Shift = 1 for r in {0,1,8,15}; shift = 2 otherwise.
- ks_load=1: cd <= ks_key; r <= 0; rk_valid <= 0. ks_adv is ignored in the same cycle (load wins).
- ks_adv=1 without load:
  - rot = {rotl28(C, shift), rotl28(D, shift)}
  - cd <= rot; rk <= PC2(rot); rk_round <= r; rk_valid <= 1; r <= r+1
  - r wraps 15 -> 0.
- Total rotation over 16 advances is 28, so cd returns to the loaded value after round 15.
- No advance: cd, rk, rk_round, r hold; rk_valid <= 0.
- Advance without a prior load operates on the reset state (all zero), giving rk = 0.
- Latency: 1 cycle, ks_adv to rk/rk_valid.
- Output path:
  - fp_en=1: c <= IP^-1({x0,x1}); c_valid <= 1.
  - else: c holds; c_valid <= 0.
  - Latency 1 cycle; accepts every cycle (fully pipelined, no backpressure).
- The two paths are independent; simultaneous ks_adv and fp_en are both serviced.
- All permutations and rotations are combinational wiring only; the only arithmetic is the 4-bit counter increment.

Test Plan:
- Reset state: assert rst=0 mid-stream -> cd_out=0, rk=0, c=0, rk_valid=0, c_valid=0 immediately, without waiting for a clock edge.
- Round 1 key: load ks_key=0xF0CCAAF556678F, advance once -> cd_out=0xE19955FAACCF1E, rk=0x1B02EFFC7072, rk_round=0, rk_valid pulses 1 cycle.
- Round 2 key: second advance from the same load -> rk=0x79AED9DBC9E5, rk_round=1.
- Full schedule: 16 advances from the same load -> 16th rk=0xCB3D8B0E17F5, rk_round=15, cd_out=0xF0CCAAF556678F, next rk_round=0.
- Final permutation: fp_en=1, x0=0x0A4CD995, x1=0x43423234 -> next cycle c=0x85E813540F0AB405, c_valid=1.
- FP corners and priority:
  - {x0,x1}=0 -> c=0.
  - All ones -> all ones.
  - 0x8000000000000000 -> 0x0000000000000040.
  - ks_load and ks_adv asserted together -> load only, no rk_valid.
